pc_sequencer: RTL and testbench

Program-counter sequencer that consumes the branch decision from the branch comparator and produces the next fetch address each cycle. Handles sequential advance, taken branches/jumps, calls (pushing a return address onto an internal return-address stack) and returns (popping it). It sits between the execute-stage branch comparator and the instruction-fetch address port. It raises a one-cycle flush pulse whenever fetch is redirected.

---
 rtl/pc_sequencer.sv | 110 +++++++++++
 tb/tb_pc_sequencer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Next-fetch-address sequencer with a return-address stack; 1-cycle latency, all outputs registered.
// stall holds every piece of state and suppresses flush; no other backpressure.
module pc_sequencer #(
    parameter int                ADDR_W   = 16,
    parameter int                DEPTH    = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       stall,
    input  logic                       br_valid,
    input  logic                       branch_taken,
    input  logic                       is_call,
    input  logic [ADDR_W-1:0]          target,
    input  logic                       ret_valid,
    output logic [ADDR_W-1:0]          pc,
    output logic                       flush,
    output logic [$clog2(DEPTH):0]     depth,
    output logic                       overflow,
    output logic                       underflow
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int DW    = PTR_W + 1;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              flush_q, flush_d;
    logic [DW-1:0]     depth_q, depth_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic [ADDR_W-1:0] stack_q [DEPTH];
    logic [ADDR_W-1:0] stack_d [DEPTH];

    logic [ADDR_W-1:0] pc_inc;
    logic [PTR_W-1:0]  top_idx;
    logic              stack_full;
    logic              stack_empty;

    assign pc_inc      = pc_q + 1'b1;
    assign top_idx     = PTR_W'(depth_q - 1'b1);
    assign stack_full  = (depth_q == DW'(DEPTH));
    assign stack_empty = (depth_q == '0);

    always_comb begin
        pc_d        = pc_q;
        flush_d     = 1'b0;
        depth_d     = depth_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        stack_d     = stack_q;
        if (!stall) begin
            if (br_valid) begin
                if (branch_taken) begin
                    pc_d    = target;
                    flush_d = 1'b1;
                    if (is_call) begin
                        // A call into a full stack still redirects; only the push is lost.
                        if (stack_full) begin
                            overflow_d = 1'b1;
                        end else begin
                            stack_d[depth_q[PTR_W-1:0]] = pc_inc;
                            depth_d                     = depth_q + 1'b1;
                        end
                    end
                end else begin
                    pc_d = pc_inc;
                end
            end else if (ret_valid) begin
                if (stack_empty) begin
                    pc_d        = pc_inc;
                    underflow_d = 1'b1;
                end else begin
                    pc_d    = stack_q[top_idx];
                    flush_d = 1'b1;
                    depth_d = depth_q - 1'b1;
                end
            end else begin
                pc_d = pc_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q        <= RESET_PC;
            flush_q     <= 1'b0;
            depth_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            flush_q     <= flush_d;
            depth_q     <= depth_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Stack contents are don't-care out of reset, so the array carries no reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stack_q <= stack_d;
        end
    end

    assign pc        = pc_q;
    assign flush     = flush_q;
    assign depth     = depth_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: queue-based reference model checked every cycle plus literal spot checks.
module tb_pc_sequencer;
    localparam int ADDR_W = 16;
    localparam int DEPTH  = 8;

    logic              clk = 1'b0;
    logic              reset, stall, br_valid, branch_taken, is_call, ret_valid;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] pc;
    logic              flush, overflow, underflow;
    logic [3:0]        depth;

    int vectors = 0;
    int errors  = 0;
    bit chk_en  = 1'b0;

    pc_sequencer #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
        .clk(clk), .reset(reset), .stall(stall), .br_valid(br_valid),
        .branch_taken(branch_taken), .is_call(is_call), .target(target),
        .ret_valid(ret_valid), .pc(pc), .flush(flush), .depth(depth),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    // Reference model: the return stack is a plain queue, pc is plain modulo-2^16 arithmetic.
    logic [15:0] m_pc;
    logic [15:0] m_stk[$];
    bit          m_flush, m_ovf, m_unf;

    always @(posedge clk) begin
        if (reset) begin
            m_pc = 16'h0000; m_flush = 0; m_ovf = 0; m_unf = 0; m_stk.delete();
        end else if (stall) begin
            m_flush = 0;
        end else if (br_valid && branch_taken) begin
            if (is_call) begin
                if (m_stk.size() == DEPTH) m_ovf = 1;
                else m_stk.push_back(m_pc + 16'd1);
            end
            m_pc = target; m_flush = 1;
        end else if (!br_valid && ret_valid && m_stk.size() > 0) begin
            m_pc = m_stk.pop_back(); m_flush = 1;
        end else begin
            if (!br_valid && ret_valid) m_unf = 1;
            m_pc = m_pc + 16'd1; m_flush = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            vectors++;
            if (pc !== m_pc || flush !== m_flush || depth !== 4'(m_stk.size())
                || overflow !== m_ovf || underflow !== m_unf) begin
                errors++;
                $display("FAIL model t=%0t: got pc=%h fl=%b d=%0d ov=%b un=%b want pc=%h fl=%b d=%0d ov=%b un=%b",
                         $time, pc, flush, depth, overflow, underflow,
                         m_pc, m_flush, m_stk.size(), m_ovf, m_unf);
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input bit br, input bit tk, input bit cl, input logic [15:0] tg,
                       input bit rt, input bit st, input bit rs);
        br_valid = br; branch_taken = tk; is_call = cl; target = tg;
        ret_valid = rt; stall = st; reset = rs;
        @(posedge clk); #1;
    endtask

    task automatic idle();   cyc(0, 0, 0, 16'h0, 0, 0, 0); endtask
    task automatic jump(input logic [15:0] tg); cyc(1, 1, 0, tg, 0, 0, 0); endtask
    task automatic call(input logic [15:0] tg); cyc(1, 1, 1, tg, 0, 0, 0); endtask
    task automatic ret();    cyc(0, 0, 0, 16'h0, 1, 0, 0); endtask

    initial begin
        reset = 1; stall = 0; br_valid = 0; branch_taken = 0; is_call = 0; target = '0; ret_valid = 0;
        cyc(0, 0, 0, 16'h0, 0, 0, 1);
        chk_en = 1;
        chk("reset_pc", pc, 0); chk("reset_depth", depth, 0); chk("reset_flush", flush, 0);
        chk("reset_flags", {overflow, underflow}, 0);

        for (int i = 1; i <= 4; i++) begin
            idle();
            chk("seq_pc", pc, i);
        end
        idle();
        jump(16'h0040);
        chk("jump_pc", pc, 16'h40); chk("jump_flush", flush, 1);
        idle();
        chk("jump_flush_drop", flush, 0); chk("jump_next", pc, 16'h41);

        cyc(0, 0, 0, 16'h0, 0, 0, 1);
        for (int i = 0; i < 5; i++) idle();
        cyc(1, 0, 1, 16'h0040, 0, 0, 0);
        chk("not_taken_pc", pc, 6); chk("not_taken_depth", depth, 0); chk("not_taken_flush", flush, 0);

        jump(16'h0010);
        call(16'h0080);
        chk("call_pc", pc, 16'h80); chk("call_depth", depth, 1); chk("call_flush", flush, 1);
        idle();
        chk("after_call_pc", pc, 16'h81); chk("after_call_flush", flush, 0);
        ret();
        chk("ret_pc", pc, 16'h11); chk("ret_depth", depth, 0); chk("ret_flush", flush, 1);

        for (int i = 0; i < 9; i++) call(16'h0100 + 16'(i));
        chk("ovf_depth", depth, 8); chk("ovf_flag", overflow, 1); chk("ovf_pc", pc, 16'h108);
        for (int k = 0; k < 7; k++) begin
            ret();
            chk("lifo_pc", pc, 16'h107 - k);
        end
        ret();
        chk("lifo_last_pc", pc, 16'h12); chk("lifo_depth", depth, 0);
        ret();
        chk("unf_flag", underflow, 1); chk("unf_pc", pc, 16'h13); chk("unf_flush", flush, 0);

        jump(16'hFFFF);
        idle();
        chk("wrap_pc", pc, 16'h0000);
        jump(16'hFFFF);
        call(16'h0200);
        ret();
        chk("wrap_ret_pc", pc, 16'h0000); chk("wrap_ret_flush", flush, 1);

        call(16'h0300);
        cyc(1, 1, 0, 16'h0020, 1, 0, 0);
        chk("br_ret_pc", pc, 16'h20); chk("br_ret_depth", depth, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 1, 1, 16'h0999, 1, 1, 0);
            chk("stall_pc", pc, 16'h20); chk("stall_flush", flush, 0);
        end
        idle();
        chk("release_pc", pc, 16'h21); chk("release_flush", flush, 0);
        ret();
        chk("stall_ret_pc", pc, 16'h0001);

        call(16'h0400);
        ret();
        chk("b2b_ret_pc", pc, 16'h0002);

        call(16'h0500);
        chk("pre_reset_ovf", overflow, 1);
        cyc(1, 1, 1, 16'h0600, 0, 0, 1);
        chk("rst_call_pc", pc, 0); chk("rst_call_depth", depth, 0);
        chk("rst_call_flags", {overflow, underflow, flush}, 0);
        idle(); idle();
        chk("post_reset_pc", pc, 2);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
